// File: rtl/axi_slave_package.sv
// Shared definitions for the AXI slave bridge request tracking path.
// Holds the request tracker size defaults, the slot index type and the
// layout of one recorded request entry.
package axi_slave_package;

  localparam int REQ_TRACKER_ENTRY_WIDTH = 64;
  localparam int REQ_TRACKER_DEPTH       = 32;
  localparam int REQ_TRACKER_IDX_WIDTH   = $clog2(REQ_TRACKER_DEPTH);

  typedef logic [REQ_TRACKER_IDX_WIDTH-1:0] req_tracker_idx_t;

  // One recorded request: AXI tag plus the mapped target address.
  typedef struct packed {
    logic [15:0] axi_tag;
    logic [47:0] addr;
  } req_tracker_entry_t;

endpackage

// File: rtl/rt_free_slot_finder.sv
// Lowest-zero priority encoder over the slot valid bitmap.
// Ports:
//   valid    in  DEPTH      slot valid bitmap
//   idx      out IDX_WIDTH  lowest index whose valid bit is 0 (0 when none free)
//   any_free out 1          at least one slot is free
module rt_free_slot_finder #(
  parameter int DEPTH     = 32,
  parameter int IDX_WIDTH = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]     valid,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 any_free
);

  always_comb begin
    idx = '0;
    // Scan downward so the last hit, and therefore the result, is the lowest free slot.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) idx = IDX_WIDTH'(i);
    end
    any_free = ~&valid;
  end

endmodule

// File: rtl/request_tracker_table.sv
// Request tracker table: entry RAM plus slot management between the A2P
// mapper (allocation) and P2A completion handling (update / retire).
// Optional feature macro: REQ_TRACKER_PARITY_EN adds one even-parity bit per
// slot and the rd_parity_err / resp_parity_err outputs.
// Ports:
//   clk, ARESET                     clock, synchronous active-high reset
//   alloc_valid/ready/data/idx      lowest-free-slot allocation handshake
//   rd_idx/rd_data/rd_hit           NUM_RD_PORTS packed combinational read ports
//   resp_rd_idx/resp_rd_data        response-side combinational read
//   resp_wr_en/idx/data             update of a valid slot
//   resp_free_en/idx                retire of a valid slot
//   occupancy, empty                valid slot count and zero flag
//   rd_parity_err, resp_parity_err  parity mismatch on a valid slot (parity build only)
//   proto_err                       sticky: update/retire hit an invalid slot
module request_tracker_table
  import axi_slave_package::*;
#(
  parameter int ENTRY_WIDTH  = REQ_TRACKER_ENTRY_WIDTH,
  parameter int DEPTH        = REQ_TRACKER_DEPTH,
  parameter int IDX_WIDTH    = $clog2(DEPTH),
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                                clk,
  input  logic                                ARESET,
  input  logic                                alloc_valid,
  output logic                                alloc_ready,
  input  logic [ENTRY_WIDTH-1:0]              alloc_data,
  output logic [IDX_WIDTH-1:0]                alloc_idx,
  input  logic [NUM_RD_PORTS*IDX_WIDTH-1:0]   rd_idx,
  output logic [NUM_RD_PORTS*ENTRY_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]             rd_hit,
  input  logic [IDX_WIDTH-1:0]                resp_rd_idx,
  output logic [ENTRY_WIDTH-1:0]              resp_rd_data,
  input  logic                                resp_wr_en,
  input  logic [IDX_WIDTH-1:0]                resp_wr_idx,
  input  logic [ENTRY_WIDTH-1:0]              resp_wr_data,
  input  logic                                resp_free_en,
  input  logic [IDX_WIDTH-1:0]                resp_free_idx,
  output logic [IDX_WIDTH:0]                  occupancy,
  output logic                                empty,
`ifdef REQ_TRACKER_PARITY_EN
  output logic [NUM_RD_PORTS-1:0]             rd_parity_err,
  output logic                                resp_parity_err,
`endif
  output logic                                proto_err
);

  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [IDX_WIDTH:0]     occ_q, occ_d;
  logic                   perr_q, perr_d;
  logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];

  logic any_free;
  logic alloc_fire, wr_legal, free_legal;

  rt_free_slot_finder #(
    .DEPTH     (DEPTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_finder (
    .valid    (valid_q),
    .idx      (alloc_idx),
    .any_free (any_free)
  );

  assign alloc_ready = any_free;

  always_comb begin
    alloc_fire = alloc_valid && any_free;
    wr_legal   = resp_wr_en   && valid_q[resp_wr_idx];
    free_legal = resp_free_en && valid_q[resp_free_idx];

    // A retired slot and the allocated slot can never coincide (one is valid,
    // the other free), so the order of these two updates does not matter.
    valid_d = valid_q;
    if (free_legal) valid_d[resp_free_idx] = 1'b0;
    if (alloc_fire) valid_d[alloc_idx]     = 1'b1;

    occ_d = occ_q + {{IDX_WIDTH{1'b0}}, alloc_fire} - {{IDX_WIDTH{1'b0}}, free_legal};

    // An update aimed at the slot being allocated sees valid=0 here and is
    // therefore dropped and flagged, leaving the allocation write in place.
    perr_d = perr_q
           | (resp_wr_en   & ~valid_q[resp_wr_idx])
           | (resp_free_en & ~valid_q[resp_free_idx]);
  end

  always_ff @(posedge clk) begin
    if (ARESET) begin
      valid_q <= '0;
      occ_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      perr_q  <= perr_d;
    end
  end

  // Entry RAM is deliberately not reset; readers qualify data with the valid bit.
  always_ff @(posedge clk) begin
    if (wr_legal)   mem_q[resp_wr_idx] <= resp_wr_data;
    if (alloc_fire) mem_q[alloc_idx]   <= alloc_data;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [IDX_WIDTH-1:0] ridx;
    assign ridx = rd_idx[p*IDX_WIDTH +: IDX_WIDTH];
    assign rd_data[p*ENTRY_WIDTH +: ENTRY_WIDTH] = mem_q[ridx];
    assign rd_hit[p] = valid_q[ridx];
  end

  assign resp_rd_data = mem_q[resp_rd_idx];
  assign occupancy    = occ_q;
  assign empty        = (occ_q == '0);
  assign proto_err    = perr_q;

`ifdef REQ_TRACKER_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_legal)   par_q[resp_wr_idx] <= ^resp_wr_data;
    if (alloc_fire) par_q[alloc_idx]   <= ^alloc_data;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_par
    logic [IDX_WIDTH-1:0] pidx;
    assign pidx = rd_idx[p*IDX_WIDTH +: IDX_WIDTH];
    assign rd_parity_err[p] = valid_q[pidx] && (par_q[pidx] != ^mem_q[pidx]);
  end

  assign resp_parity_err = valid_q[resp_rd_idx] &&
                           (par_q[resp_rd_idx] != ^mem_q[resp_rd_idx]);
`endif

endmodule

// File: tb/tb_request_tracker_table.sv
module tb_request_tracker_table;
  localparam int EW = 64;
  localparam int D  = 32;
  localparam int IW = 5;
  localparam int NP = 2;

  logic          clk = 1'b0;
  logic          ARESET;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [EW-1:0] alloc_data;
  logic [IW-1:0] alloc_idx;
  logic [NP*IW-1:0] rd_idx;
  logic [NP*EW-1:0] rd_data;
  logic [NP-1:0] rd_hit;
  logic [IW-1:0] resp_rd_idx;
  logic [EW-1:0] resp_rd_data;
  logic          resp_wr_en;
  logic [IW-1:0] resp_wr_idx;
  logic [EW-1:0] resp_wr_data;
  logic          resp_free_en;
  logic [IW-1:0] resp_free_idx;
  logic [IW:0]   occupancy;
  logic          empty;
  logic          proto_err;
`ifdef REQ_TRACKER_PARITY_EN
  logic [NP-1:0] rd_parity_err;
  logic          resp_parity_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  request_tracker_table #(
    .ENTRY_WIDTH  (EW),
    .DEPTH        (D),
    .NUM_RD_PORTS (NP)
  ) dut (
    .clk           (clk),
    .ARESET        (ARESET),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_data    (alloc_data),
    .alloc_idx     (alloc_idx),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .rd_hit        (rd_hit),
    .resp_rd_idx   (resp_rd_idx),
    .resp_rd_data  (resp_rd_data),
    .resp_wr_en    (resp_wr_en),
    .resp_wr_idx   (resp_wr_idx),
    .resp_wr_data  (resp_wr_data),
    .resp_free_en  (resp_free_en),
    .resp_free_idx (resp_free_idx),
    .occupancy     (occupancy),
    .empty         (empty),
`ifdef REQ_TRACKER_PARITY_EN
    .rd_parity_err   (rd_parity_err),
    .resp_parity_err (resp_parity_err),
`endif
    .proto_err     (proto_err)
  );

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [IW-1:0] i0, input logic [IW-1:0] i1);
    rd_idx = {i1, i0};
    #1;
  endtask

  initial begin
    ARESET = 1'b1; alloc_valid = 1'b0; alloc_data = '0; rd_idx = '0;
    resp_rd_idx = '0; resp_wr_en = 1'b0; resp_wr_idx = '0; resp_wr_data = '0;
    resp_free_en = 1'b0; resp_free_idx = '0;
    tick(); tick();
    ARESET = 1'b0;
    #1;
    chk("rst_ready", 64'(alloc_ready), 64'd1);
    chk("rst_idx",   64'(alloc_idx),   64'd0);
    chk("rst_empty", 64'(empty),       64'd1);
    chk("rst_occ",   64'(occupancy),   64'd0);
    chk("rst_perr",  64'(proto_err),   64'd0);

    // 1: three allocations A, B, C
    alloc_valid = 1'b1; alloc_data = 64'hAAAA_0000_0000_000A; #1;
    chk("a0_idx", 64'(alloc_idx), 64'd0);
    tick(); alloc_data = 64'hBBBB_0000_0000_000B; #1;
    chk("a1_idx", 64'(alloc_idx), 64'd1);
    tick(); alloc_data = 64'hCCCC_0000_0000_000C; #1;
    chk("a2_idx", 64'(alloc_idx), 64'd2);
    tick(); alloc_valid = 1'b0;
    chk("a_occ",   64'(occupancy), 64'd3);
    chk("a_empty", 64'(empty),     64'd0);
    set_rd(5'd1, 5'd2);
    chk("rd0_data", rd_data[EW-1:0],   64'hBBBB_0000_0000_000B);
    chk("rd0_hit",  64'(rd_hit[0]),    64'd1);
    chk("rd1_data", rd_data[2*EW-1:EW], 64'hCCCC_0000_0000_000C);
    set_rd(5'd5, 5'd0);
    chk("rd_miss", 64'(rd_hit), 64'b10);

    // 2: fill the remaining slots 3..31 with data 0x100+i
    alloc_valid = 1'b1;
    for (int i = 3; i < D; i++) begin
      alloc_data = 64'h100 + 64'(i);
      tick();
    end
    chk("full_ready", 64'(alloc_ready), 64'd0);
    chk("full_occ",   64'(occupancy),   64'd32);
    tick();  // alloc_valid held while full: ignored, no error
    alloc_valid = 1'b0;
    chk("full_hold_occ", 64'(occupancy), 64'd32);
    chk("full_no_perr",  64'(proto_err), 64'd0);
    resp_free_en = 1'b1; resp_free_idx = 5'd5;
    tick(); resp_free_en = 1'b0; #1;
    chk("ret5_idx",   64'(alloc_idx),   64'd5);
    chk("ret5_ready", 64'(alloc_ready), 64'd1);
    chk("ret5_occ",   64'(occupancy),   64'd31);

    // 3: free slot 3, then alloc (lands on 3) together with retire of 0
    resp_free_en = 1'b1; resp_free_idx = 5'd3;
    tick(); resp_free_en = 1'b0; #1;
    chk("ret3_idx", 64'(alloc_idx), 64'd3);
    alloc_valid = 1'b1; alloc_data = 64'h3333;
    resp_free_en = 1'b1; resp_free_idx = 5'd0;
    tick(); alloc_valid = 1'b0; resp_free_en = 1'b0;
    set_rd(5'd3, 5'd0);
    chk("ar_hit3",   64'(rd_hit[0]),     64'd1);
    chk("ar_hit0",   64'(rd_hit[1]),     64'd0);
    chk("ar_data3",  rd_data[EW-1:0],    64'h3333);
    chk("ar_occ",    64'(occupancy),     64'd30);
    chk("ar_nextix", 64'(alloc_idx),     64'd0);

    // 4: update and retire slot 2 in the same cycle
    resp_wr_en = 1'b1; resp_wr_idx = 5'd2; resp_wr_data = 64'hDEAD;
    resp_free_en = 1'b1; resp_free_idx = 5'd2;
    tick(); resp_wr_en = 1'b0; resp_free_en = 1'b0;
    resp_rd_idx = 5'd2; set_rd(5'd2, 5'd1);
    chk("uf_data", resp_rd_data,     64'hDEAD);
    chk("uf_hit",  64'(rd_hit[0]),   64'd0);
    chk("uf_perr", 64'(proto_err),   64'd0);
    chk("uf_occ",  64'(occupancy),   64'd29);

    // legal update of valid slot 1 keeps it valid
    resp_wr_en = 1'b1; resp_wr_idx = 5'd1; resp_wr_data = 64'h1234_5678;
    tick(); resp_wr_en = 1'b0;
    resp_rd_idx = 5'd1; #1;
    chk("upd_data", resp_rd_data,   64'h1234_5678);
    chk("upd_hit",  64'(rd_hit[1]), 64'd1);
    chk("upd_occ",  64'(occupancy), 64'd29);

    // 5: retire 7 legally, then again while invalid
    resp_free_en = 1'b1; resp_free_idx = 5'd7;
    tick(); #1;
    chk("r7_perr0", 64'(proto_err), 64'd0);
    chk("r7_occ",   64'(occupancy), 64'd28);
    tick(); resp_free_en = 1'b0; #1;
    chk("r7_perr1", 64'(proto_err), 64'd1);
    chk("r7_occ2",  64'(occupancy), 64'd28);
    // update on invalid slot 7 is dropped; retire kept the old data
    resp_wr_en = 1'b1; resp_wr_idx = 5'd7; resp_wr_data = 64'hBAD;
    tick(); resp_wr_en = 1'b0;
    resp_rd_idx = 5'd7; #1;
    chk("drop_data", resp_rd_data, 64'h107);
    // alloc and update of the same (free) slot 0: alloc wins
    alloc_valid = 1'b1; alloc_data = 64'hA110C;
    resp_wr_en = 1'b1; resp_wr_idx = 5'd0; resp_wr_data = 64'hBAD0;
    tick(); alloc_valid = 1'b0; resp_wr_en = 1'b0;
    resp_rd_idx = 5'd0; #1;
    chk("aw_data", resp_rd_data,   64'hA110C);
    chk("aw_occ",  64'(occupancy), 64'd29);
    tick(); tick();
    chk("perr_sticky", 64'(proto_err), 64'd1);

`ifdef REQ_TRACKER_PARITY_EN
    set_rd(5'd4, 5'd6);
    chk("par_clean", 64'(rd_parity_err), 64'd0);
    dut.mem_q[4][0] = ~dut.mem_q[4][0];
    #1;
    chk("par_err", 64'(rd_parity_err), 64'b01);
`endif

    // 6: reset in the middle of a fill
    ARESET = 1'b1; tick(); ARESET = 1'b0; #1;
    alloc_valid = 1'b1; alloc_data = 64'h55;
    tick(); tick();
    chk("mid_occ", 64'(occupancy), 64'd2);
    alloc_valid = 1'b0; ARESET = 1'b1;
    tick(); ARESET = 1'b0; #1;
    chk("mr_occ",   64'(occupancy), 64'd0);
    chk("mr_idx",   64'(alloc_idx), 64'd0);
    chk("mr_empty", 64'(empty),     64'd1);
    chk("mr_perr",  64'(proto_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
